// File: rtl/fnd_pkg.sv
// Shared segment encodings and hex-to-segment lookup for the FND scan controller.
// Segment order is {dp,g,f,e,d,c,b,a}, active-low.
package fnd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 7;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex, input logic dp);
        logic [7:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        // Decimal point is active-low like the segments.
        if (dp) seg[DP_BIT] = 1'b0;
        return seg;
    endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational segment decoder for the currently scanned digit; a dark digit
// forces every segment (including dp) off.
module fnd_seg_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] seg
);

    assign seg = dark ? SEG_BLANK : hex_to_seg(hex, dp);

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode 7-segment scan controller with frame-synchronous
// shadow buffering, per-digit blink and leading-zero suppression.
// Optional macro FND_BRIGHTNESS_EN adds i_duty[3:0] for per-slot duty dimming.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int NUM_DIGITS   = 4,
    parameter int BLINK_FRAMES = 125
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] i_hex,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    input  logic [NUM_DIGITS-1:0]   i_blink,
    input  logic                    i_lz_en,
`ifdef FND_BRIGHTNESS_EN
    input  logic [3:0]              i_duty,
`endif
    output logic [7:0]              o_fnd_data,
    output logic [NUM_DIGITS-1:0]   o_fnd_com,
    output logic                    o_frame_done
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    load;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_phase;

    logic [4*NUM_DIGITS-1:0] sh_hex;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    sh_lz_en;

    logic [NUM_DIGITS-1:0]   suppressed;
    logic                    lz_run;
    logic                    dark_p0;
    logic                    slot_on;
    logic [7:0]              seg_p0;
    logic [NUM_DIGITS-1:0]   com_p0;

    assign tick         = (div_cnt == DIV_LAST);
    assign load         = tick && (idx == IDX_LAST);
    assign o_frame_done = load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Shadow buffer and blink phase both change only on the frame boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_hex      <= '0;
            sh_dp       <= '0;
            sh_blank    <= '1;
            sh_blink    <= '0;
            sh_lz_en    <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (load) begin
            sh_hex   <= i_hex;
            sh_dp    <= i_dp;
            sh_blank <= i_blank;
            sh_blink <= i_blink;
            sh_lz_en <= i_lz_en;
            if (blink_cnt == BLK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        suppressed = '0;
        lz_run     = sh_lz_en;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_run        = lz_run && (sh_hex[4*k +: 4] == 4'h0) && !sh_dp[k];
            suppressed[k] = lz_run;
        end
    end

`ifdef FND_BRIGHTNESS_EN
    logic [3:0]  sh_duty;
    logic [31:0] on_limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     sh_duty <= 4'hF;
        else if (load) sh_duty <= i_duty;
    end

    assign on_limit = ((32'(sh_duty) + 32'd1) * 32'(DIV)) >> 4;
    assign slot_on  = (32'(div_cnt) < on_limit);
`else
    assign slot_on = 1'b1;
`endif

    // ---- stage p0: current slot decode ----
    assign dark_p0 = sh_blank[idx] || suppressed[idx] || (sh_blink[idx] && blink_phase);

    fnd_seg_decoder u_seg_decoder (
        .hex  (sh_hex[{idx, 2'b00} +: 4]),
        .dp   (sh_dp[idx]),
        .dark (dark_p0),
        .seg  (seg_p0)
    );

    always_comb begin
        com_p0 = '1;
        if (!dark_p0 && slot_on) com_p0[idx] = 1'b0;
    end

    // ---- stage p1: registered pin drivers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_fnd_data <= SEG_BLANK;
            o_fnd_com  <= '1;
        end else begin
            o_fnd_data <= dark_p0 ? SEG_BLANK : seg_p0;
            o_fnd_com  <= com_p0;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: CLK_HZ=1000, SCAN_HZ=250 (DIV=4),
// 4 digits, BLINK_FRAMES=2; each frame load pushes the next frame's 16 expected outputs.
module tb_fnd_scan_controller;

    localparam int ND   = 4;
    localparam int DIVC = 4;
    localparam int BF   = 2;
    localparam int FRM  = ND * DIVC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] hex = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  blink = 4'h0;
    logic        lz_en = 1'b0;
    logic [3:0]  duty = 4'hF;
    logic [7:0]  fnd_data;
    logic [3:0]  fnd_com;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int loads = 0;
    logic [11:0] sb_q[$];

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    fnd_scan_controller #(
        .CLK_HZ(1000), .SCAN_HZ(250), .NUM_DIGITS(ND), .BLINK_FRAMES(BF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_hex        (hex),
        .i_dp         (dp),
        .i_blank      (blank),
        .i_blink      (blink),
        .i_lz_en      (lz_en),
`ifdef FND_BRIGHTNESS_EN
        .i_duty       (duty),
`endif
        .o_fnd_data   (fnd_data),
        .o_fnd_com    (fnd_com),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Expected frame built from the inputs the DUT samples at this load edge.
    task automatic push_frame();
        int top;
        int limit;
        bit phase;
        bit dark;
        logic [3:0] nib;
        logic [3:0] com;
        logic [7:0] dat;
        loads++;
        phase = ((loads / BF) % 2) == 1;
        top = 0;
        for (int d = ND - 1; d >= 0; d--) begin
            nib = hex[4*d +: 4];
            if (top == 0 && (nib != 4'h0 || dp[d])) top = d;
        end
`ifdef FND_BRIGHTNESS_EN
        limit = ((int'(duty) + 1) * DIVC) / 16;
`else
        limit = DIVC;
`endif
        for (int d = 0; d < ND; d++) begin
            nib  = hex[4*d +: 4];
            dark = blank[d] || (lz_en && d > top) || (blink[d] && phase);
            dat  = dark ? 8'hFF : (seg_tab[nib] & (dp[d] ? 8'h7F : 8'hFF));
            for (int v = 0; v < DIVC; v++) begin
                com = 4'hF;
                if (!dark && v < limit) com[d] = 1'b0;
                sb_q.push_back({com, dat});
            end
        end
    endtask

    task automatic compare_cycle();
        logic [11:0] exp;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check_eq("fnd_com", {28'd0, fnd_com}, {28'd0, exp[11:8]});
            check_eq("fnd_data", {24'd0, fnd_data}, {24'd0, exp[7:0]});
        end
        check_eq("frame_done", {31'd0, frame_done}, {31'd0, (cyc % FRM) == FRM - 1});
    endtask

    task automatic step();
        @(posedge clk);
        if (cyc % FRM == FRM - 1) push_frame();
        cyc++;
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        sb_q.delete();
        loads = 0;
        cyc = 0;
        for (int i = 0; i <= FRM; i++) sb_q.push_back({4'hF, 8'hFF});
        compare_cycle();
    endtask

    initial begin
        hex = 16'h1234;
        do_reset();
        run(40);

        // Mid-frame change must wait for the next load.
        hex = 16'h5678;
        run(40);

        hex = 16'h0070;
        lz_en = 1'b1;
        run(36);
        dp = 4'b1000;
        run(36);

        dp = 4'b0000;
        lz_en = 1'b0;
        hex = 16'hABCD;
        blink = 4'b0001;
        run(FRM * 6);

        blink = 4'b0000;
        hex = 16'h1234;
        run(FRM * 2);
        while (cyc % FRM != 9) step();
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_async_com", {28'd0, fnd_com}, 32'h0000000F);
        check_eq("rst_async_data", {24'd0, fnd_data}, 32'h000000FF);
        check_eq("rst_async_fd", {31'd0, frame_done}, 32'd0);
        do_reset();
        run(40);

`ifdef FND_BRIGHTNESS_EN
        duty = 4'd3;
        run(40);
        duty = 4'd15;
        run(40);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Parametrised multiplexed 7-segment scan controller for NUM_DIGITS common-anode digits. It has its own scan-rate divider and double-buffers the per-digit hex/dp/blank/blink inputs at frame boundaries so the display never tears. It adds per-digit blink and leading-zero suppression. It sits between the time/sensor formatting logic and the board FND pins, and replaces fixed 4-digit, fixed-rate scanning.

Parameters:
CLK_HZ, 100_000_000, system clock frequency
SCAN_HZ, 1000, digit-slot rate; DIV = CLK_HZ/SCAN_HZ, must be >= 16
NUM_DIGITS, 4, number of digits (2..8); digit 0 = rightmost (LSD)
BLINK_FRAMES, 125, full frames per blink half-period (>= 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
i_hex  in  4*NUM_DIGITS  digit values, nibble k = digit k, 0x0..0xF
i_dp  in  NUM_DIGITS  decimal point request per digit
i_blank  in  NUM_DIGITS  force digit dark
i_blink  in  NUM_DIGITS  digit dark during blink-off phase
i_lz_en  in  1  leading-zero suppression enable
o_fnd_data  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
o_fnd_com  out  NUM_DIGITS  digit enables, active-low, at most one low
o_frame_done  out  1  one-clk pulse when the shadow buffer loads

Behaviour:
- Interface: reset is asynchronous and active-high. Clock is clk.
- Divider: div_cnt runs 0..DIV-1. tick = (div_cnt == DIV-1). div_cnt wraps to 0 on tick.
- Scan index idx runs 0..NUM_DIGITS-1 and advances on tick. It wraps from NUM_DIGITS-1 to 0.
- Shadow load: on a tick with idx == NUM_DIGITS-1, i_hex/i_dp/i_blank/i_blink/i_lz_en are captured into shadow registers. o_frame_done pulses high for that same cycle.
  - Input changes between loads have no effect on the display.
- Blink: blink_cnt counts frame loads 0..BLINK_FRAMES-1. blink_phase toggles when blink_cnt wraps. blink_phase = 1 means off-phase.
- Leading-zero suppression (shadow lz_en = 1):
  - Scan from digit NUM_DIGITS-1 downward. A digit is suppressed while its hex == 0 and its dp == 0.
  - Suppression stops at the first digit that fails this test.
  - Digit 0 is never suppressed.
- A digit is dark when any of these holds: shadow blank, suppressed, or (shadow blink AND blink_phase).
  - Dark digit: o_fnd_com all ones, o_fnd_data 8'hFF.
- Segment map (bits g..a):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
  - bit7 is cleared when dp = 1.
- Output timing: o_fnd_data and o_fnd_com are registered. They reflect idx one clk after idx changes.
  - o_fnd_com drives bit idx low for a lit digit.
- Reset values:
  - div_cnt = 0, idx = 0, blink_cnt = 0, blink_phase = 0.
  - shadow hex = 0, shadow blank = all ones.
  - o_fnd_com = all ones, o_fnd_data = 8'hFF, o_frame_done = 0.
  - The display stays dark until the first shadow load.
- Reset mid-frame: outputs go dark immediately (async). The scan restarts at idx 0 with the shadow blank.
- Simultaneous events: a blink wrap and a shadow load on the same tick both apply. The new phase is used from digit 0 of the new frame.

Optional Feature:
FND_BRIGHTNESS_EN
- Defined: adds input i_duty[3:0]. Within each slot, o_fnd_com stays active only while div_cnt < ((i_duty+1)*DIV)/16; after that it is all ones.
  - o_fnd_data is unchanged.
  - i_duty is sampled at shadow load.
  - i_duty = 15 gives a full slot.
- Undefined: no port; the enable covers the full slot.

Decomposition:
- Package fnd_pkg holds:
  - localparams SEG_0..SEG_F and SEG_BLANK = 8'hFF
  - function hex_to_seg(hex, dp)
  - DP_BIT = 7
- One sub-module, fnd_seg_decoder: combinational hex + dp + dark -> 8-bit segments. It is instantiated once on the idx-selected digit.

Test Plan:
All scenarios use CLK_HZ = 1000, SCAN_HZ = 250 (DIV = 4), NUM_DIGITS = 4, BLINK_FRAMES = 2, unless stated.
1. Reset release, i_hex = 16'h1234, blank = 0 -> dark for the first frame. o_frame_done pulses at clk 15. The next frame shows com 1110/1101/1011/0111 with data 99/B0/A4/F9, each for 4 clks.
2. Change i_hex to 16'h5678 mid-frame -> the current frame still shows 1234. The new digits appear only after the next o_frame_done.
3. i_hex = 16'h0070, i_lz_en = 1 -> digits 3 and 2 dark, digit 1 = F8, digit 0 = C0. With i_dp[3] = 1, digit 3 shows 40 and digit 2 shows C0.
4. i_blink = 4'b0001 -> digit 0 is lit for 2 frames, dark for 2 frames, alternating. The other digits stay lit throughout.
5. Assert reset while idx = 2 -> o_fnd_com = 1111 and o_fnd_data = FF the same cycle. After release, the display is dark until the first load.
6. FND_BRIGHTNESS_EN with DIV = 16 and i_duty = 3 -> each lit digit's com is low for 4 of 16 clks per slot. With i_duty = 15, com is low for all 16 clks.
